sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO extending the basic synchronous FIFO: configurable width and power-of-two depth, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with a clear input. It buffers data between a producer and a consumer in the same clock domain. It is the standard buffering block for data paths that need back-pressure margin or error reporting.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 17 +
 rtl/sync_fifo_flags.sv | 97 +++++++++
 tb/tb_sync_fifo_flags.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helper, parameter-legality checks and error-flag type for sync_fifo_flags
package sync_fifo_pkg;
  localparam int MIN_DEPTH = 2;
  localparam int MIN_WIDTH = 1;
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit width_ok(input int width);
    return width >= MIN_WIDTH;
  endfunction
  function automatic bit depth_ok(input int depth);
    return depth >= MIN_DEPTH && (depth & (depth - 1)) == 0;
  endfunction
  function automatic bit af_ok(input int af, input int depth);
    return af >= 1 && af <= depth;
  endfunction
  function automatic bit ae_ok(input int ae, input int depth);
    return ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH storage; ports clk, we/waddr/wdata (sync write), raddr/rdata (async read), no reset
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost_full/almost_empty thresholds and sticky overflow/underflow.
// Ports: clk, rst (async, active-low); write side wr_en/wr_data; read side rd_en/rd_data/rd_valid; err_clr;
// status count/empty/full/almost_empty/almost_full/overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  if (!width_ok(WIDTH) || !depth_ok(DEPTH) || !af_ok(AF_LEVEL, DEPTH) || !ae_ok(AE_LEVEL, DEPTH)) begin : g_bad_params
    $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
  end
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  err_flags_t       err_q, err_d;
  logic [WIDTH-1:0] mem_rd;
  logic             rd_acc, wr_acc;
  assign count        = count_q;
  assign empty        = count_q == '0;
  assign full         = count_q == PW'(DEPTH);
  assign almost_empty = count_q <= PW'(AE_LEVEL);
  assign almost_full  = count_q >= PW'(AF_LEVEL);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;
  // a write to a full FIFO still fits when a read frees a slot on the same edge
  always_comb begin
    rd_acc          = rd_en && !empty;
    wr_acc          = wr_en && (!full || rd_acc);
    wr_ptr_d        = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d        = rd_ptr_q + PW'(rd_acc);
    count_d         = count_q + PW'(wr_acc) - PW'(rd_acc);
    err_d.overflow  = (err_q.overflow && !err_clr) || (wr_en && !wr_acc);
    err_d.underflow = (err_q.underflow && !err_clr) || (rd_en && !rd_acc);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  sync_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(mem_rd)
  );
`ifdef SYNC_FIFO_FWFT_EN
  // head word is shown while non-empty; forced to 0 when empty so reset reads back 0
  assign rd_data  = empty ? '0 : mem_rd;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  always_comb begin
    rd_data_d  = rd_acc ? mem_rd : rd_data_q;
    rd_valid_d = rd_acc;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed table-driven bench for sync_fifo_flags (WIDTH=8, DEPTH=16)
module tb_sync_fifo_flags;
  logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic [4:0] count;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  int         total = 0, bad = 0;
  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       clr;
    logic [4:0] cnt;
    logic       emp, ful, ae, af, ovf, unf;
  } vec_t;
  vec_t v[$];
  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic xfer(input logic wr, input logic [7:0] wd, input logic [7:0] exp, input logic [4:0] cnt);
    wr_en = wr;
    wr_data = wd;
    rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", 32'(rd_data), 32'(exp));
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    step();
`else
    step();
    chk("pop_data", 32'(rd_data), 32'(exp));
    chk("pop_valid", 32'(rd_valid), 32'd1);
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("pop_count", 32'(count), 32'(cnt));
  endtask
  initial begin
    for (int i = 1; i <= 16; i++)
      v.push_back('{1'b1, 8'(i), 1'b0, 5'(i), 1'b0, i == 16, i <= 2, i >= 14, 1'b0, 1'b0});
    v.push_back('{1'b1, 8'h63, 1'b0, 5'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    v.push_back('{1'b0, 8'h00, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b1;
    foreach (v[k]) begin
      wr_en = v[k].wr;
      wr_data = v[k].wd;
      err_clr = v[k].clr;
      step();
      wr_en = 1'b0;
      err_clr = 1'b0;
      chk("vec_count", 32'(count), 32'(v[k].cnt));
      chk("vec_empty", 32'(empty), 32'(v[k].emp));
      chk("vec_full", 32'(full), 32'(v[k].ful));
      chk("vec_ae", 32'(almost_empty), 32'(v[k].ae));
      chk("vec_af", 32'(almost_full), 32'(v[k].af));
      chk("vec_ovf", 32'(overflow), 32'(v[k].ovf));
      chk("vec_unf", 32'(underflow), 32'(v[k].unf));
    end
    for (int i = 1; i <= 16; i++) xfer(1'b0, 8'h00, 8'(i), 5'(16 - i));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("drain_unf", 32'(underflow), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid_low", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_data_held", 32'(rd_data), 32'd16);
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("unf_cleared", 32'(underflow), 32'd0);
    for (int i = 1; i <= 16; i++) push(8'(i));
    xfer(1'b1, 8'hAA, 8'd1, 5'd16);
    chk("full_rw_full", 32'(full), 32'd1);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 16; i++) xfer(1'b0, 8'h00, 8'(i), 5'(17 - i));
    xfer(1'b0, 8'h00, 8'hAA, 5'd0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'd5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("empty_rw_unf", 32'(underflow), 32'd1);
    chk("empty_rw_count", 32'(count), 32'd1);
    xfer(1'b0, 8'h00, 8'd5, 5'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    push(8'd100);
    push(8'd101);
    push(8'd102);
    for (int k = 0; k < 40; k++) xfer(1'b1, 8'(103 + k), 8'(100 + k), 5'd3);
    xfer(1'b0, 8'h00, 8'd140, 5'd2);
    xfer(1'b0, 8'h00, 8'd141, 5'd1);
    xfer(1'b0, 8'h00, 8'd142, 5'd0);
    rd_en = 1'b1;
    step();
    chk("wrap_unf", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    step();
    chk("clr_vs_set", 32'(underflow), 32'd1);
    rd_en = 1'b0;
    step();
    err_clr = 1'b0;
    chk("clr_alone", 32'(underflow), 32'd0);
    push(8'd1);
    push(8'd2);
    #3 rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    push(8'd9);
    xfer(1'b0, 8'h00, 8'd9, 5'd0);
    push(8'd7);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_show_data", 32'(rd_data), 32'd7);
    chk("fwft_show_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_pop_valid", 32'(rd_valid), 32'd0);
    chk("fwft_pop_empty", 32'(empty), 32'd1);
`else
    chk("std_no_pop_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("std_pop_data", 32'(rd_data), 32'd7);
    chk("std_pop_valid", 32'(rd_valid), 32'd1);
    step();
    chk("std_valid_falls", 32'(rd_valid), 32'd0);
    chk("std_data_held", 32'(rd_data), 32'd7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
